// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the multi-port CPU bus arbiter: FSM state codes
// and the timeout counter width helper.
package cpu_bus_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS     = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // Counter must hold 0..timeout; a disabled timeout (0) still gets one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_rr_picker.sv
// Combinational winner selection: first requesting port at or after the
// pointer (round-robin) or lowest requesting index (fixed priority).
module cpu_bus_arbiter_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_rr_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int w_base;

  // Fold an index in [0, 2N) back into [0, N).
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Fixed priority is round-robin with the pointer pinned at zero.
  assign w_base = i_rr_mode ? int'(i_ptr) : 0;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[wrap(w_base + k)]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(wrap(w_base + k));
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// N-port arbiter onto one shared memory bus. One transaction at a time walks
// IDLE -> BUS -> RELEASE -> IDLE; RELEASE carries the per-port done/error pulse.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int N_CPU   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int RR_MODE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CPU-1:0]            req_read,
  input  logic [N_CPU-1:0]            req_write,
  input  logic [N_CPU*ADDR_W-1:0]     req_addr,
  input  logic [N_CPU*DATA_W-1:0]     req_wdata,
  output logic [N_CPU-1:0]            port_dn,
  output logic [N_CPU-1:0]            port_err,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [$clog2(N_CPU)-1:0]    grant_idx,
  output logic                        bus_busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_read_q,
  output logic                        mem_write_q,
  input  logic                        mem_read_dn,
  input  logic                        mem_write_dn
);

  localparam int IDX_W = $clog2(N_CPU);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CPU - 1);

  arb_state_e        r_state,    w_state_nxt;
  logic [IDX_W-1:0]  r_grant,    w_grant_nxt;
  logic [IDX_W-1:0]  r_ptr,      w_ptr_nxt;
  logic              r_is_read,  w_is_read_nxt;
  logic [N_CPU-1:0]  r_port_dn,  w_port_dn_nxt;
  logic [N_CPU-1:0]  r_port_err, w_port_err_nxt;
  logic [DATA_W-1:0] r_rdata,    w_rdata_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_read_q,   w_read_q_nxt;
  logic              r_write_q,  w_write_q_nxt;
  logic              r_busy,     w_busy_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;

  logic [N_CPU-1:0]  w_req;
  logic [IDX_W-1:0]  w_win;
  logic              w_win_valid;
  logic              w_mem_dn;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;
  logic [N_CPU-1:0]  w_grant_onehot;

  // A port holding both read and write still counts as one requester.
  assign w_req = req_read | req_write;

  cpu_bus_arbiter_rr_picker #(
    .N     (N_CPU),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_idx     (w_win),
    .o_valid   (w_win_valid)
  );

  // Only the completion matching the issued strobe ends the transaction.
  assign w_mem_dn       = r_is_read ? mem_read_dn : mem_write_dn;
  assign w_cnt_inc      = r_cnt + CNT_W'(1);
  assign w_timeout      = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_grant_onehot = {{(N_CPU-1){1'b0}}, 1'b1} << r_grant;

  // Next-state and next-output computation; everything holds unless a state says otherwise.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_is_read_nxt   = r_is_read;
    w_port_dn_nxt   = '0;
    w_port_err_nxt  = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_read_q_nxt    = r_read_q;
    w_write_q_nxt   = r_write_q;
    w_busy_nxt      = r_busy;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      ARB_IDLE: begin
        w_read_q_nxt  = 1'b0;
        w_write_q_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        if (w_win_valid) begin
          // Reads go first; a pending write on the same port is re-arbitrated later.
          w_grant_nxt     = w_win;
          w_is_read_nxt   = req_read[w_win];
          w_mem_addr_nxt  = req_addr[w_win*ADDR_W +: ADDR_W];
          w_mem_wdata_nxt = req_wdata[w_win*DATA_W +: DATA_W];
          w_read_q_nxt    = req_read[w_win];
          w_write_q_nxt   = ~req_read[w_win];
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          if (RR_MODE != 0) begin
            w_ptr_nxt = (w_win == LAST_IDX) ? '0 : w_win + IDX_W'(1);
          end
          w_state_nxt = ARB_BUS;
        end
      end

      ARB_BUS: begin
        if (w_mem_dn) begin
          // A completion arriving on the timeout cycle wins over the error.
          if (r_is_read) begin
            w_rdata_nxt = mem_rdata;
          end
          w_read_q_nxt  = 1'b0;
          w_write_q_nxt = 1'b0;
          w_port_dn_nxt = w_grant_onehot;
          w_state_nxt   = ARB_RELEASE;
        end else if (w_timeout) begin
          w_read_q_nxt   = 1'b0;
          w_write_q_nxt  = 1'b0;
          w_port_dn_nxt  = w_grant_onehot;
          w_port_err_nxt = w_grant_onehot;
          w_cnt_nxt      = w_cnt_inc;
          w_state_nxt    = ARB_RELEASE;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      ARB_RELEASE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ARB_IDLE;
      end

      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_is_read   <= 1'b0;
      r_port_dn   <= '0;
      r_port_err  <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_read_q    <= 1'b0;
      r_write_q   <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_is_read   <= w_is_read_nxt;
      r_port_dn   <= w_port_dn_nxt;
      r_port_err  <= w_port_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_read_q    <= w_read_q_nxt;
      r_write_q   <= w_write_q_nxt;
      r_busy      <= w_busy_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign port_dn     = r_port_dn;
  assign port_err    = r_port_err;
  assign port_rdata  = r_rdata;
  assign grant_idx   = r_grant;
  assign bus_busy    = r_busy;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_read_q  = r_read_q;
  assign mem_write_q = r_write_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter. Two instances share stimulus: a
// round-robin one with an 8-cycle timeout and a fixed-priority one with a
// 4-cycle timeout. Expected port completions are queued per instance when
// stimulus is applied and popped when a port_dn pulse appears.
module tb_cpu_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_read, req_write;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_read_dn, mem_write_dn;

  logic [3:0]  rr_port_dn, rr_port_err, fp_port_dn, fp_port_err;
  logic [31:0] rr_port_rdata, fp_port_rdata;
  logic [1:0]  rr_grant_idx, fp_grant_idx;
  logic        rr_bus_busy, fp_bus_busy;
  logic [31:0] rr_mem_addr, fp_mem_addr, rr_mem_wdata, fp_mem_wdata;
  logic        rr_mem_read_q, fp_mem_read_q, rr_mem_write_q, fp_mem_write_q;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.N_CPU(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .port_dn(rr_port_dn), .port_err(rr_port_err), .port_rdata(rr_port_rdata),
    .grant_idx(rr_grant_idx), .bus_busy(rr_bus_busy),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_q(rr_mem_read_q), .mem_write_q(rr_mem_write_q),
    .mem_read_dn(mem_read_dn), .mem_write_dn(mem_write_dn)
  );

  cpu_bus_arbiter #(.N_CPU(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .port_dn(fp_port_dn), .port_err(fp_port_err), .port_rdata(fp_port_rdata),
    .grant_idx(fp_grant_idx), .bus_busy(fp_bus_busy),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_q(fp_mem_read_q), .mem_write_q(fp_mem_write_q),
    .mem_read_dn(mem_read_dn), .mem_write_dn(mem_write_dn)
  );

  typedef struct {
    int          idx;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  bit   mon_rr, mon_fp;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_dn(input bit to_rr, input bit to_fp, input int idx,
                           input bit err, input bit rd, input logic [31:0] data);
    exp_t e;
    e.idx = idx; e.err = err; e.rd = rd; e.data = data;
    if (to_rr) q_rr.push_back(e);
    if (to_fp) q_fp.push_back(e);
  endtask

  // Compare one instance's completion pulse against the head of its queue.
  task automatic score(input string tag, input bit en, input bit is_rr,
                       input logic [3:0] dn, input logic [3:0] err, input logic [31:0] rdata);
    exp_t       e;
    logic [3:0] one;
    int         depth;
    if (!en) return;
    if (dn == 4'b0) begin
      if (err != 4'b0) check({tag, " err without dn"}, 64'(err), 64'(0));
      return;
    end
    depth = is_rr ? q_rr.size() : q_fp.size();
    if (depth == 0) begin
      check({tag, " unexpected dn"}, 64'(dn), 64'(0));
      return;
    end
    if (is_rr) e = q_rr.pop_front();
    else       e = q_fp.pop_front();
    one = 4'b0001 << e.idx;
    check({tag, " dn"}, 64'(dn), 64'(one));
    check({tag, " err"}, 64'(err), e.err ? 64'(one) : 64'(0));
    if (e.rd) check({tag, " rdata"}, 64'(rdata), 64'(e.data));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    score("rr", mon_rr, 1'b1, rr_port_dn, rr_port_err, rr_port_rdata);
    score("fp", mon_fp, 1'b0, fp_port_dn, fp_port_err, fp_port_rdata);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_read = '0; req_write = '0;
    mem_read_dn = 1'b0; mem_write_dn = 1'b0;
    mon_rr = 1'b0; mon_fp = 1'b0;
    ticks(2);
    rst = 1'b0;
    q_rr.delete();
    q_fp.delete();
  endtask

  task automatic drain_check(input string tag);
    check({tag, " rr pending"}, 64'(q_rr.size()), 64'(0));
    check({tag, " fp pending"}, 64'(q_fp.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_read = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_read_dn = 1'b0; mem_write_dn = 1'b0;

    // Reset state: every output zero on both instances.
    do_reset();
    check("reset rr ctl", 64'({rr_port_dn, rr_port_err, rr_bus_busy, rr_mem_read_q, rr_mem_write_q, rr_grant_idx}), 64'(0));
    check("reset rr data", 64'({rr_mem_addr, rr_port_rdata}), 64'(0));
    check("reset fp ctl", 64'({fp_port_dn, fp_port_err, fp_bus_busy, fp_mem_read_q, fp_mem_write_q, fp_grant_idx}), 64'(0));
    check("reset fp data", 64'({fp_mem_addr, fp_port_rdata}), 64'(0));

    // 1: single read on port 2, memory answers on the first BUS cycle.
    mon_rr = 1'b1; mon_fp = 1'b1;
    req_addr[2*32 +: 32] = 32'h0000_0200;
    mem_rdata = 32'hDEAD_BEEF;
    req_read  = 4'b0100;
    expect_dn(1'b1, 1'b1, 2, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    check("t1 grant", 64'(rr_grant_idx), 64'(2));
    check("t1 strobes", 64'({rr_bus_busy, rr_mem_read_q, rr_mem_write_q}), 64'(3'b110));
    check("t1 addr", 64'(rr_mem_addr), 64'(32'h0000_0200));
    mem_read_dn = 1'b1;
    tick();
    check("t1 dn on 3rd cycle", 64'(rr_port_dn), 64'(4'b0100));
    check("t1 release", 64'({rr_bus_busy, rr_mem_read_q}), 64'(2'b10));
    req_read = '0; mem_read_dn = 1'b0; mem_rdata = '0;
    tick();
    check("t1 idle", 64'({rr_bus_busy, rr_port_dn}), 64'(0));
    check("t1 rdata hold", 64'(rr_port_rdata), 64'(32'hDEAD_BEEF));
    drain_check("t1");

    // 2: all ports read continuously; round-robin rotates, fixed priority sticks at 0.
    do_reset();
    mon_rr = 1'b1; mon_fp = 1'b1;
    for (int p = 0; p < 4; p++) req_addr[p*32 +: 32] = 32'(32'h1000 * (p + 1));
    req_read = 4'hF;
    mem_read_dn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_rdata = 32'(32'hA000_0000 + k);
      expect_dn(1'b1, 1'b0, k % 4, 1'b0, 1'b1, mem_rdata);
      expect_dn(1'b0, 1'b1, 0,     1'b0, 1'b1, mem_rdata);
      tick();
      check("t2 rr grant", 64'(rr_grant_idx), 64'(k % 4));
      check("t2 fp grant", 64'(fp_grant_idx), 64'(0));
      check("t2 rr addr", 64'(rr_mem_addr), 64'(32'(32'h1000 * ((k % 4) + 1))));
      tick();
      if (k == 4) req_read = '0;
      tick();
      check("t2 busy gap", 64'({rr_bus_busy, fp_bus_busy}), 64'(0));
    end
    mem_read_dn = 1'b0;
    drain_check("t2");

    // 3: write on port 1 never completes; 8-cycle timeout raises dn and err.
    do_reset();
    mon_rr = 1'b1;
    req_addr[1*32 +: 32]  = 32'h0000_0100;
    req_wdata[1*32 +: 32] = 32'hCAFE_F00D;
    req_write = 4'b0010;
    expect_dn(1'b1, 1'b0, 1, 1'b1, 1'b0, 32'h0);
    tick();
    check("t3 strobes", 64'({rr_bus_busy, rr_mem_read_q, rr_mem_write_q}), 64'(3'b101));
    check("t3 wdata", 64'(rr_mem_wdata), 64'(32'hCAFE_F00D));
    ticks(7);
    check("t3 still waiting", 64'({rr_mem_write_q, rr_port_dn}), 64'(5'b10000));
    tick();
    check("t3 timeout", 64'({rr_mem_write_q, rr_port_dn, rr_port_err}), 64'({1'b0, 4'b0010, 4'b0010}));
    req_write = '0;
    tick();
    check("t3 idle", 64'(rr_bus_busy), 64'(0));
    drain_check("t3");

    // 4: port 3 read+write; read first, wrong-type dn ignored, write on next grant.
    do_reset();
    mon_rr = 1'b1; mon_fp = 1'b1;
    req_addr[3*32 +: 32]  = 32'h0000_0040;
    req_wdata[3*32 +: 32] = 32'h1234_5678;
    mem_rdata = 32'h5555_AAAA;
    req_read = 4'b1000; req_write = 4'b1000;
    mem_write_dn = 1'b1;
    expect_dn(1'b1, 1'b1, 3, 1'b0, 1'b1, 32'h5555_AAAA);
    expect_dn(1'b1, 1'b1, 3, 1'b0, 1'b0, 32'h0);
    tick();
    check("t4 read first", 64'({rr_mem_read_q, rr_mem_write_q, fp_mem_read_q, fp_mem_write_q}), 64'(4'b1010));
    check("t4 addr", 64'(rr_mem_addr), 64'(32'h0000_0040));
    tick();
    check("t4 wrong dn ignored", 64'({rr_mem_read_q, rr_port_dn, fp_mem_read_q, fp_port_dn}), 64'({1'b1, 4'b0, 1'b1, 4'b0}));
    mem_read_dn = 1'b1;
    tick();
    req_read = '0; mem_read_dn = 1'b0;
    tick();
    tick();
    check("t4 write grant", 64'({rr_mem_read_q, rr_mem_write_q}), 64'(2'b01));
    check("t4 wdata", 64'(rr_mem_wdata), 64'(32'h1234_5678));
    tick();
    req_write = '0; mem_write_dn = 1'b0;
    tick();
    drain_check("t4");

    // 5: reset on the 2nd BUS cycle aborts silently and clears the pointer.
    do_reset();
    mon_rr = 1'b1; mon_fp = 1'b1;
    req_addr[2*32 +: 32] = 32'h0000_0200;
    req_read = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5 rr abort", 64'({rr_port_dn, rr_port_err, rr_bus_busy, rr_mem_read_q, rr_mem_write_q, rr_grant_idx}), 64'(0));
    check("t5 rr abort data", 64'(rr_mem_addr), 64'(0));
    check("t5 fp abort", 64'({fp_port_dn, fp_port_err, fp_bus_busy, fp_mem_read_q, fp_mem_write_q, fp_grant_idx}), 64'(0));
    rst = 1'b0;
    req_read = 4'hF; mem_read_dn = 1'b1;
    mem_rdata = 32'h5EED_0005;
    expect_dn(1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h5EED_0005);
    tick();
    check("t5 pointer reset", 64'(rr_grant_idx), 64'(0));
    tick();
    req_read = '0; mem_read_dn = 1'b0;
    tick();
    drain_check("t5");

    // 6: dn arrives on the same cycle the 4-cycle timeout expires; dn wins.
    do_reset();
    mon_rr = 1'b1; mon_fp = 1'b1;
    req_addr[0 +: 32] = 32'h0000_0600;
    mem_rdata = 32'h600D_600D;
    req_read = 4'b0001;
    expect_dn(1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h600D_600D);
    tick();
    ticks(3);
    check("t6 waiting", 64'({fp_mem_read_q, fp_port_dn}), 64'(5'b10000));
    mem_read_dn = 1'b1;
    tick();
    check("t6 dn wins", 64'({fp_port_dn, fp_port_err}), 64'({4'b0001, 4'b0000}));
    req_read = '0; mem_read_dn = 1'b0;
    tick();
    drain_check("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
